// File: rtl/sd_word_bridge.sv
// Word-to-byte bridge in front of the sdcard byte-access block: one 32-bit load/store
// becomes four serial byte commands, big-endian, guarded by a per-byte stall watchdog.
`timescale 1ns/1ps
module sd_word_bridge #(
    parameter int TIMEOUT_W = 24,
    parameter int SETTLE    = 1
) (
    input  logic        clk,
    input  logic        xrst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] req_rdata,
    output logic        req_busy,
    output logic        req_done,
    output logic        req_err,
    output logic [31:0] sd_addr,
    output logic [7:0]  sd_write_data,
    input  logic [7:0]  sd_read_data,
    output logic        sd_read,
    output logic        sd_write,
    input  logic        sd_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_ISSUE,
        S_SETTLE,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WDOG_MAX    = '1;
    localparam logic [TIMEOUT_W-1:0] SETTLE_LAST = (SETTLE > 0) ? TIMEOUT_W'(SETTLE - 1) : '0;

    state_t               state_q, state_d;
    logic [31:0]          base_q, base_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [31:0]          sd_addr_q, sd_addr_d;
    logic [7:0]           sd_wdata_q, sd_wdata_d;
    logic                 op_write_q, op_write_d;
    logic                 err_q, err_d;
    logic [1:0]           idx_q, idx_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic [1:0]           issue_idx;
    logic                 load_issue;

    // The watchdog counter doubles as the settle counter: the two never run at once.
    always_comb begin
        // NOTE: every signal assigned here gets its default first, so no path can infer a latch.
        state_d    = state_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        sd_addr_d  = sd_addr_q;
        sd_wdata_d = sd_wdata_q;
        op_write_d = op_write_q;
        err_d      = err_q;
        idx_d      = idx_q;
        wdog_d     = wdog_q;
        issue_idx  = idx_q;
        load_issue = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_read || req_write) begin
                    base_d     = req_addr & ~32'h3;
                    wdata_d    = req_wdata;
                    op_write_d = req_write;
                    err_d      = 1'b0;
                    idx_d      = 2'd0;
                    wdog_d     = '0;
                    state_d    = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (sd_ready) begin
                    load_issue = 1'b1;
                    state_d    = S_ISSUE;
                end else if (wdog_q == WDOG_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = (SETTLE == 0) ? S_WAIT_ACK : S_SETTLE;
            end
            S_SETTLE: begin
                if (wdog_q == SETTLE_LAST) begin
                    wdog_d  = '0;
                    state_d = S_WAIT_ACK;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                end
            end
            S_WAIT_ACK: begin
                if (sd_ready) begin
                    if (!op_write_q) begin
                        rdata_d[8*(3-int'(idx_q)) +: 8] = sd_read_data;
                    end
                    if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        issue_idx  = idx_q + 2'd1;
                        load_issue = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end else if (wdog_q == WDOG_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Address and write byte are registered on entry to ISSUE and held until the next one.
        if (load_issue) begin
            sd_addr_d = base_q + {30'd0, issue_idx};
            if (op_write_q) begin
                sd_wdata_d = wdata_q[8*(3-int'(issue_idx)) +: 8];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge xrst) begin
        // NOTE: every flop is reset, so a transaction abandoned by reset leaves no residue.
        if (!xrst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            sd_addr_q  <= '0;
            sd_wdata_q <= '0;
            op_write_q <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            sd_addr_q  <= sd_addr_d;
            sd_wdata_q <= sd_wdata_d;
            op_write_q <= op_write_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            wdog_q     <= wdog_d;
        end
    end

    assign req_rdata     = rdata_q;
    assign req_err       = err_q;
    assign req_done      = (state_q == S_DONE);
    assign req_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign sd_addr       = sd_addr_q;
    assign sd_write_data = sd_wdata_q;
    assign sd_read       = (state_q == S_ISSUE) && !op_write_q;
    assign sd_write      = (state_q == S_ISSUE) && op_write_q;

endmodule

// File: tb/tb_sd_word_bridge.sv
// Directed bench for sd_word_bridge: one instance with the default watchdog against a
// configurable card model, one with TIMEOUT_W=4 against a card that can stall.
`timescale 1ns/1ps
module tb_sd_word_bridge;

    logic clk  = 1'b0;
    logic xrst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Instance A (default parameters)
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [31:0] req_rdata;
    logic        req_busy, req_done, req_err;
    logic [31:0] sd_addr;
    logic [7:0]  sd_write_data, sd_read_data;
    logic        sd_read, sd_write, sd_ready;

    // Instance B (short watchdog)
    logic        req_read_t = 1'b0, req_write_t = 1'b0;
    logic [31:0] req_addr_t = '0, req_wdata_t = '0;
    logic [31:0] req_rdata_t;
    logic        req_busy_t, req_done_t, req_err_t;
    logic [31:0] sd_addr_t;
    logic [7:0]  sd_write_data_t, sd_read_data_t;
    logic        sd_read_t, sd_write_t, sd_ready_t;

    sd_word_bridge u_dut (
        .clk(clk), .xrst(xrst),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rdata(req_rdata), .req_busy(req_busy), .req_done(req_done), .req_err(req_err),
        .sd_addr(sd_addr), .sd_write_data(sd_write_data), .sd_read_data(sd_read_data),
        .sd_read(sd_read), .sd_write(sd_write), .sd_ready(sd_ready)
    );

    sd_word_bridge #(.TIMEOUT_W(4)) u_dut_t (
        .clk(clk), .xrst(xrst),
        .req_read(req_read_t), .req_write(req_write_t), .req_addr(req_addr_t), .req_wdata(req_wdata_t),
        .req_rdata(req_rdata_t), .req_busy(req_busy_t), .req_done(req_done_t), .req_err(req_err_t),
        .sd_addr(sd_addr_t), .sd_write_data(sd_write_data_t), .sd_read_data(sd_read_data_t),
        .sd_read(sd_read_t), .sd_write(sd_write_t), .sd_ready(sd_ready_t)
    );

    // Card model A: goes not-ready for busy_len cycles after each command.
    logic [7:0]  mem [4];
    int          busy_len = 0, busy_cnt = 0;
    int          n_pulse = 0, n_rd = 0, n_wr = 0, bad_pulse = 0;
    logic        card_rdy = 1'b1;
    logic        force_busy = 1'b0;
    logic [31:0] log_addr [64];
    logic [7:0]  log_wdata [64];

    assign sd_ready     = card_rdy && !force_busy;
    assign sd_read_data = mem[sd_addr[1:0]];

    always @(negedge clk) begin
        if (sd_read || sd_write) begin
            if (!sd_ready) bad_pulse++;
            log_addr[n_pulse % 64]  = sd_addr;
            log_wdata[n_pulse % 64] = sd_write_data;
            n_pulse++;
            if (sd_read)  n_rd++;
            if (sd_write) n_wr++;
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        card_rdy = (busy_cnt == 0);
    end

    int          n_done = 0, done_cyc = 0;
    logic [31:0] done_rdata;
    logic        done_err, done_busy;
    always @(negedge clk) begin
        if (req_done) begin
            n_done++;
            done_cyc   = cyc;
            done_rdata = req_rdata;
            done_err   = req_err;
            done_busy  = req_busy;
        end
    end

    // Card model B: always ready with 0x5A, until it stalls for good after command stall_at.
    int   pulses_t = 0, stall_at = 0;
    logic stall_en = 1'b0;
    assign sd_ready_t     = !(stall_en && (pulses_t >= stall_at));
    assign sd_read_data_t = 8'h5A;

    always @(negedge clk) begin
        if (sd_read_t || sd_write_t) pulses_t++;
    end

    int          n_done_t = 0, done_cyc_t = 0;
    logic [31:0] done_rdata_t;
    logic        done_err_t, done_busy_t;
    always @(negedge clk) begin
        if (req_done_t) begin
            n_done_t++;
            done_cyc_t   = cyc;
            done_rdata_t = req_rdata_t;
            done_err_t   = req_err_t;
            done_busy_t  = req_busy_t;
        end
    end

    int n_pass = 0, n_checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic start_req(input bit sel, input bit rd, input bit wr,
                             input logic [31:0] addr, input logic [31:0] wd, output int t);
        @(posedge clk); #1;
        if (!sel) begin
            req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd;
        end else begin
            req_read_t = rd; req_write_t = wr; req_addr_t = addr; req_wdata_t = wd;
        end
        t = cyc;
        @(posedge clk); #1;
        req_read = 1'b0; req_write = 1'b0; req_read_t = 1'b0; req_write_t = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int n0, input int max_cyc, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(posedge clk);
            seen = sel ? (n_done_t > n0) : (n_done > n0);
        end
        if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int          t, p0, r0, w0, d0, bp0, p1, q0;
        logic [31:0] w;

        mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_ctrl",  32'({req_busy, req_done, req_err, sd_read, sd_write}), 32'd0);
        check("rst_rdata", req_rdata, 32'd0);
        check("rst_sdbus", sd_addr | 32'(sd_write_data), 32'd0);
        xrst = 1'b1;
        repeat (2) @(posedge clk);

        // Ideal read at unaligned 0x103
        p0 = n_pulse; r0 = n_rd; w0 = n_wr; d0 = n_done;
        start_req(1'b0, 1'b1, 1'b0, 32'h103, 32'h0, t);
        check("rd_busy", 32'(req_busy), 32'd1);
        wait_done(1'b0, d0, 40, "rd");
        check("rd_latency", 32'(done_cyc - t), 32'd14);
        check("rd_data", done_rdata, 32'hDEADBEEF);
        check("rd_err", 32'(done_err), 32'd0);
        check("rd_busy_at_done", 32'(done_busy), 32'd0);
        check("rd_reads", 32'(n_rd - r0), 32'd4);
        check("rd_writes", 32'(n_wr - w0), 32'd0);
        for (int i = 0; i < 4; i++)
            check($sformatf("rd_addr%0d", i), log_addr[(p0 + i) % 64], 32'h100 + 32'(i));

        // Word write
        w = 32'h12345678;
        p0 = n_pulse; r0 = n_rd; w0 = n_wr; d0 = n_done;
        start_req(1'b0, 1'b0, 1'b1, 32'h200, w, t);
        wait_done(1'b0, d0, 40, "wr");
        repeat (5) @(posedge clk);
        check("wr_latency", 32'(done_cyc - t), 32'd14);
        check("wr_writes", 32'(n_wr - w0), 32'd4);
        check("wr_reads", 32'(n_rd - r0), 32'd0);
        check("wr_done_pulses", 32'(n_done - d0), 32'd1);
        check("wr_err", 32'(done_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr_addr%0d", i), log_addr[(p0 + i) % 64], 32'h200 + 32'(i));
            check($sformatf("wr_byte%0d", i), 32'(log_wdata[(p0 + i) % 64]), 32'(w[31-8*i -: 8]));
        end

        // Busy card: not ready before the first command and for 50 cycles after each one
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        busy_len = 50; force_busy = 1'b1;
        r0 = n_rd; d0 = n_done; bp0 = bad_pulse;
        start_req(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, t);
        repeat (10) @(posedge clk); #1;
        check("busy_hold_in_wait_rdy", 32'(n_rd - r0), 32'd0);
        force_busy = 1'b0;
        wait_done(1'b0, d0, 400, "busy");
        check("busy_reads", 32'(n_rd - r0), 32'd4);
        check("busy_no_pulse_unready", 32'(bad_pulse - bp0), 32'd0);
        check("busy_data", done_rdata, 32'h11223344);
        check("busy_err", 32'(done_err), 32'd0);
        check("busy_waited", 32'((done_cyc - t) >= 200), 32'd1);

        // Write request while a read is in flight is ignored
        busy_len = 0;
        repeat (55) @(posedge clk);
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
        r0 = n_rd; w0 = n_wr; d0 = n_done;
        start_req(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, t);
        repeat (4) @(posedge clk); #1;
        req_write = 1'b1; req_addr = 32'h500; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_write = 1'b0;
        wait_done(1'b0, d0, 40, "ign");
        repeat (20) @(posedge clk); #1;
        check("ign_reads", 32'(n_rd - r0), 32'd4);
        check("ign_writes", 32'(n_wr - w0), 32'd0);
        check("ign_data", done_rdata, 32'hA1B2C3D4);
        check("ign_done_pulses", 32'(n_done - d0), 32'd1);
        check("ign_idle", 32'(req_busy), 32'd0);

        // Reset while waiting for the ack of byte 1
        mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;
        busy_len = 50;
        p0 = n_pulse;
        start_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, t);
        for (int i = 0; i < 200 && (n_pulse - p0) < 2; i++) @(posedge clk);
        check("rstmid_two_pulses", 32'(n_pulse - p0), 32'd2);
        repeat (5) @(posedge clk); #1;
        xrst = 1'b0;
        #1;
        check("rstmid_ctrl", 32'({req_busy, req_done, req_err, sd_read, sd_write}), 32'd0);
        check("rstmid_addr", sd_addr, 32'd0);
        check("rstmid_rdata", req_rdata, 32'd0);
        p1 = n_pulse;
        busy_len = 0;
        repeat (3) @(posedge clk); #1;
        xrst = 1'b1;
        repeat (60) @(posedge clk); #1;
        check("rstmid_no_more_pulses", 32'(n_pulse - p1), 32'd0);
        d0 = n_done;
        start_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, t);
        wait_done(1'b0, d0, 40, "rstmid_after");
        check("rstmid_after_data", done_rdata, 32'hDEADBEEF);
        check("rstmid_after_err", 32'(done_err), 32'd0);

        // Watchdog timeout on instance B: card stalls after the 2nd command
        q0 = pulses_t; d0 = n_done_t;
        stall_at = pulses_t + 2; stall_en = 1'b1;
        start_req(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, t);
        wait_done(1'b1, d0, 100, "to");
        check("to_err", 32'(done_err_t), 32'd1);
        check("to_busy_at_done", 32'(done_busy_t), 32'd0);
        check("to_partial_data", done_rdata_t, 32'h5A000000);
        check("to_delay_window", 32'((done_cyc_t - t) >= 20 && (done_cyc_t - t) <= 26), 32'd1);
        repeat (10) @(posedge clk); #1;
        check("to_no_third_pulse", 32'(pulses_t - q0), 32'd2);
        check("to_err_held", 32'(req_err_t), 32'd1);

        // Next request clears the error and completes
        stall_en = 1'b0;
        q0 = pulses_t; d0 = n_done_t;
        start_req(1'b1, 1'b1, 1'b0, 32'h404, 32'h0, t);
        check("to_err_cleared", 32'(req_err_t), 32'd0);
        wait_done(1'b1, d0, 40, "to2");
        check("to2_err", 32'(done_err_t), 32'd0);
        check("to2_data", done_rdata_t, 32'h5A5A5A5A);
        check("to2_pulses", 32'(pulses_t - q0), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
